// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared types and helpers for the adder share arbiter
// Purpose: result slot state encoding and round-robin pointer advance.
// Ports: none (package).
package adder_arb_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  // Pointer moves to the requester just after the winner, wrapping at nreq.
  function automatic int unsigned rr_next_ptr(input int unsigned idx,
                                              input int unsigned nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first valid requester at or above ptr, wrapping mod NREQ.
// Ports: req_valid - per-requester request; ptr - search start index;
//        grant - one-hot or zero; grant_idx - encoded winner; grant_any - any winner.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      // First hit in search order wins; later hits are ignored.
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unsigned_adder.sv
// rtl/unsigned_adder.sv - N-bit unsigned adder, sum modulo 2^N
// Purpose: plain combinational adder shared by the arbiter.
// Ports: a, b - N-bit operands; sum - (a + b) mod 2^N.
module unsigned_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - one unsigned adder shared by NREQ requesters
// Purpose: round-robin arbitration onto a single adder with a one-entry result slot.
// Ports: clk, rst (async, active high);
//        req_valid/req_ready - per-requester handshake; req_a/req_b - packed operands;
//        rsp_valid/rsp_ready - result handshake; rsp_id/rsp_sum/rsp_ovf - result fields.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_ovf
);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;

  slot_state_t     state_q, state_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            ovf_q, ovf_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic [N-1:0]    op_a, op_b, add_sum;
  logic            slot_free;
  logic            fire;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign op_a = req_a[int'(grant_idx)*N +: N];
  assign op_b = req_b[int'(grant_idx)*N +: N];

  unsigned_adder #(
    .N (N)
  ) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_ovf   = ovf_q;

  // The slot can take a new result if empty or if its occupant retires this edge.
  assign slot_free = !rsp_valid || rsp_ready;
  // rst gates ready directly since the arbiter itself is purely combinational.
  assign req_ready = (rst || !slot_free) ? '0 : grant;
  assign fire      = grant_any && slot_free && !rst;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (fire) begin
      state_d = FULL;
      sum_d   = add_sum;
      // A wrapped sum is smaller than either operand exactly when there was a carry out.
      ovf_d   = (add_sum < op_a);
      id_d    = grant_idx;
      ptr_d   = IDW'(rr_next_ptr(32'(grant_idx), NREQ));
    end else if (rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;

  localparam int N    = 8;
  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic        rsp_ovf;

  int tests = 0;
  int fails = 0;

  // Reference model: one held result plus the round-robin start index.
  int m_ptr   = 0;
  bit m_valid = 1'b0;
  int m_id    = 0;
  int m_sum   = 0;
  bit m_ovf   = 1'b0;

  adder_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int opa(input int i);
    return int'(req_a[i*8 +: 8]);
  endfunction

  function automatic int opb(input int i);
    return int'(req_b[i*8 +: 8]);
  endfunction

  // Winner: first valid requester counting up from m_ptr, modulo NREQ; -1 if none.
  function automatic int win_idx();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    w = win_idx();
    if (rst || w < 0) return 4'b0000;
    if (m_valid && !rsp_ready) return 4'b0000;
    return 4'(1 << w);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr   <= 0;
      m_valid <= 1'b0;
    end else if (exp_ready() != 4'b0000) begin
      m_valid <= 1'b1;
      m_id    <= win_idx();
      m_sum   <= (opa(win_idx()) + opb(win_idx())) % 256;
      m_ovf   <= (opa(win_idx()) + opb(win_idx())) >= 256;
      m_ptr   <= (win_idx() + 1) % NREQ;
    end else if (rsp_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model_req_ready", 32'(req_ready), 32'(exp_ready()));
    check("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid && !rst) begin
      check("model_rsp_id",  32'(rsp_id),  32'(m_id));
      check("model_rsp_sum", 32'(rsp_sum), 32'(m_sum));
      check("model_rsp_ovf", 32'(rsp_ovf), 32'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #2;
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_id",    32'(rsp_id),    0);
    check("reset_rsp_sum",   32'(rsp_sum),   0);
    check("reset_rsp_ovf",   32'(rsp_ovf),   0);
    check("reset_req_ready", 32'(req_ready), 0);
    step();
    step();
    rst       = 1'b0;
    req_valid = 4'b0000;

    // Single requester 2: 1 + 1.
    req_valid = 4'b0100;
    set_op(2, 8'd1, 8'd1);
    rsp_ready = 1'b1;
    #2;
    check("single_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000;
    #2;
    check("single_valid", 32'(rsp_valid), 1);
    check("single_id",    32'(rsp_id),    2);
    check("single_sum",   32'(rsp_sum),   2);
    check("single_ovf",   32'(rsp_ovf),   0);

    // Overflow cases on requester 0 (ptr is 3, search wraps to 0).
    set_op(0, 8'd1, 8'd255);
    req_valid = 4'b0001;
    step();
    set_op(0, 8'd255, 8'd253);
    #2;
    check("ovf1_id",  32'(rsp_id),  0);
    check("ovf1_sum", 32'(rsp_sum), 0);
    check("ovf1_ovf", 32'(rsp_ovf), 1);
    step();
    req_valid = 4'b0000;
    #2;
    check("ovf2_sum", 32'(rsp_sum), 252);
    check("ovf2_ovf", 32'(rsp_ovf), 1);

    // Round robin with all requesters valid after a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(10*i + 1), 8'(i + 100));
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #2;
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) check("rr_id", 32'(rsp_id), 32'((k - 1) % 4));
      step();
    end
    #2;
    check("rr_last_id",  32'(rsp_id),  3);
    check("rr_last_sum", 32'(rsp_sum), 134);
    req_valid = 4'b0000;
    step();

    // Backpressure: hold id 1 (3 + 4) while requester 3 waits.
    set_op(1, 8'd3, 8'd4);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    step();
    req_valid = 4'b1000;
    set_op(3, 8'd20, 8'd22);
    set_op(1, 8'd99, 8'd99);
    for (int k = 0; k < 3; k++) begin
      #2;
      check("bp_ready", 32'(req_ready), 0);
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_id",    32'(rsp_id),    1);
      check("bp_sum",   32'(rsp_sum),   7);
      step();
    end
    rsp_ready = 1'b1;
    #2;
    check("bp_release_ready", 32'(req_ready), 32'h8);
    step();
    set_op(3, 8'd0, 8'd0);
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    #2;
    check("nobubble_valid", 32'(rsp_valid), 1);
    check("nobubble_id",    32'(rsp_id),    3);
    check("sample_sum",     32'(rsp_sum),   42);
    step();
    #2;
    check("sample_hold_sum", 32'(rsp_sum), 42);

    // Async reset while FULL.
    req_valid = 4'b1100;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(rsp_valid), 0);
    check("arst_ready", 32'(req_ready), 0);
    step();
    rst = 1'b0;
    #2;
    check("post_rst_ready", 32'(req_ready), 32'h4);
    rsp_ready = 1'b1;
    step();
    req_valid = 4'b0000;
    #2;
    check("post_rst_id",  32'(rsp_id),  2);
    check("post_rst_sum", 32'(rsp_sum), 123);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
